// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch requester
// and the load/store requester of the multicycle core. One access is in
// flight at a time. The winner is granted for the single ISSUE cycle, the
// arbiter waits MEM_LAT cycles for a read, and then pulses rvalid in DONE.
// A write skips the wait and is acknowledged with an rvalid pulse.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  memory read latency in cycles (1 or more)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   if_req/if_addr    fetch request and address
//   if_gnt/if_rvalid  fetch accept pulse, fetch data valid pulse
//   if_rdata          fetch data, registered and held
//   d_req/d_we        data request, write (1) or read (0)
//   d_addr/d_wdata    data address and store data
//   d_gnt/d_rvalid    data accept pulse, load data valid or store ack pulse
//   d_rdata           load data, registered and held
//   mem_en/mem_we     memory access strobe and write enable
//   mem_addr          memory address, held from ISSUE until back in IDLE
//   mem_wdata         memory write data, held from ISSUE until back in IDLE
//   mem_rdata         memory read data
//   busy              high whenever the arbiter is not IDLE
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, conflicting requests alternate using
//                       a last-winner register. Otherwise data always wins.

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arbStateT;

  arbStateT         state;
  arbStateT         nextState;
  logic             winData;
  logic             weLatched;
  logic             pickData;
  logic [CNT_W-1:0] waitCnt;

  // Winner selection, evaluated only while IDLE. With round robin, a
  // conflict goes to whichever requester was not served last; lastWasData
  // resets to 0 so that data wins the first conflict after reset.
`ifdef ARB_ROUND_ROBIN_EN
  logic lastWasData;
  assign pickData = d_req && (!if_req || !lastWasData);
`else
  assign pickData = d_req;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs. Strobes are decoded from the state
  // so that an asynchronous reset clears them immediately.
  always_comb begin
    nextState = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = weLatched;
        d_gnt     = winData;
        if_gnt    = !winData;
        nextState = weLatched ? DONE : WAIT;
      end
      WAIT: begin
        if (waitCnt == '0) begin
          nextState = DONE;
        end
      end
      DONE: begin
        d_rvalid  = winData;
        if_rvalid = !winData;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath registers. The access is latched when leaving IDLE and held
  // until the next access is latched. Fetches never write, so their write
  // data is latched as zero. The wait counter runs MEM_LAT-1 down to 0 and
  // read data is captured on the edge that ends the last WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winData     <= 1'b0;
      weLatched   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      waitCnt     <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastWasData <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            winData   <= pickData;
            weLatched <= pickData && d_we;
            mem_addr  <= pickData ? d_addr : if_addr;
            mem_wdata <= pickData ? d_wdata : '0;
          end
        end
        ISSUE: begin
          waitCnt <= CNT_W'(MEM_LAT - 1);
`ifdef ARB_ROUND_ROBIN_EN
          lastWasData <= winData;
`endif
        end
        WAIT: begin
          if (waitCnt == '0) begin
            if (winData) begin
              d_rdata <= mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
